// File: rtl/mips_core_pkg.sv
// Shared types for the store queue: entry layout, pointer type and dispatch FSM states.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core_pkg;

  localparam int SQ_DEPTH   = 8;
  localparam int SQ_AL_ID_W = 6;
  localparam int ADDR_WIDTH = `ADDR_WIDTH;
  localparam int DATA_WIDTH = `DATA_WIDTH;

  // Index bits plus one wrap bit, so full and empty are distinguishable.
  typedef logic [$clog2(SQ_DEPTH):0] sq_ptr_t;

  typedef enum logic {
    SQ_IDLE = 1'b0,
    SQ_REQ  = 1'b1
  } sq_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  resolved;
    logic                  retired;
    logic [SQ_AL_ID_W-1:0] active_list_id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } sq_entry_t;

endpackage

// File: rtl/sq_bypass_search.sv
// Age-ordered store-to-load search: walks entries from just below lookup_tail down to head,
// stopping at the first resolved address match or the first unresolved store.
module sq_bypass_search
  import mips_core_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic [PTR_W-1:0]  lookup_tail,
  input  logic [PTR_W-1:0]  head,
  input  logic [DEPTH-1:0]  entry_valid,
  input  logic [DEPTH-1:0]  entry_resolved,
  input  logic [ADDR_W-1:0] entry_addr [DEPTH],
  input  logic [DATA_W-1:0] entry_data [DEPTH],
  output logic              hit,
  output logic [IDX_W-1:0]  hit_index,
  output logic [DATA_W-1:0] hit_data,
  output logic              unknown
);

  logic [PTR_W-1:0] span;
  logic [IDX_W-1:0] idx;
  logic             done;

  assign span = lookup_tail - head;

  always_comb begin
    hit       = 1'b0;
    hit_index = '0;
    hit_data  = '0;
    unknown   = 1'b0;
    done      = 1'b0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = lookup_tail[IDX_W-1:0] - IDX_W'(k + 1);
      if (lookup_valid && !done && (PTR_W'(k) < span) && entry_valid[idx]) begin
        // An unresolved store younger than any match could alias the load.
        if (!entry_resolved[idx]) begin
          unknown = 1'b1;
          done    = 1'b1;
        end else if (entry_addr[idx] == lookup_addr) begin
          hit       = 1'b1;
          hit_index = idx;
          hit_data  = entry_data[idx];
          done      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/store_queue_ctrl.sv
// In-order store queue: allocates at tail, resolves via exec, retires in order at ret,
// writes retired stores to the d-cache from head, and answers load bypass lookups.
module store_queue_ctrl
  import mips_core_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = `ADDR_WIDTH,
  parameter int DATA_W  = `DATA_WIDTH,
  parameter int AL_ID_W = 6,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int PTR_W  = IDX_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc_valid,
  input  logic [AL_ID_W-1:0] alloc_active_list_id,
  output logic               alloc_ready,
  output logic [IDX_W-1:0]   alloc_index,
  input  logic               exec_valid,
  input  logic [IDX_W-1:0]   exec_index,
  input  logic [ADDR_W-1:0]  exec_addr,
  input  logic [DATA_W-1:0]  exec_data,
  input  logic               retire_valid,
  input  logic [AL_ID_W-1:0] retire_active_list_id,
  output logic               retire_mismatch,
  input  logic               flush,
  output logic               dispatch_valid,
  output logic [IDX_W-1:0]   dispatch_index,
  output logic [ADDR_W-1:0]  dispatch_addr,
  output logic [DATA_W-1:0]  dispatch_data,
  input  logic               cache_done,
  input  logic               lookup_valid,
  input  logic [ADDR_W-1:0]  lookup_addr,
  input  logic [PTR_W-1:0]   lookup_tail,
  output logic               bypass_hit,
  output logic [IDX_W-1:0]   bypass_index,
  output logic [DATA_W-1:0]  bypass_data,
  output logic               bypass_unknown,
  output sq_state_e          dbg_state
);

  // Handshakes: an allocation happens on a cycle with alloc_valid && alloc_ready; a cache
  // write is offered while dispatch_valid is high, held stable, and ends on cache_done.
  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  ptr_t             head_q, ret_q, tail_q, live_cnt;
  logic [IDX_W-1:0] head_idx, ret_idx, tail_idx;
  logic [DEPTH-1:0] valid_q, resolved_q, retired_q, flush_mask;
  logic [AL_ID_W-1:0] id_q   [DEPTH];
  logic [ADDR_W-1:0]  addr_q [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];
  sq_state_e        state_q, state_d;
  logic             full, do_alloc, do_exec, retire_ok, do_retire, do_free;

  assign head_idx = head_q[IDX_W-1:0];
  assign ret_idx  = ret_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  assign full        = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign alloc_ready = !full;
  assign alloc_index = tail_idx;

  assign do_alloc        = alloc_valid && !full && !flush;
  assign do_exec         = exec_valid && valid_q[exec_index] && !flush;
  assign retire_ok       = retire_valid && (ret_q != tail_q) &&
                           (id_q[ret_idx] == retire_active_list_id);
  assign retire_mismatch = retire_valid && !retire_ok;
  assign do_retire       = retire_ok && !flush;
  assign do_free         = (state_q == SQ_REQ) && cache_done;

  // Entries in [ret, tail) are the ones a flush squashes.
  assign live_cnt = tail_q - ret_q;
  always_comb begin
    flush_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      flush_mask[i] = ({1'b0, IDX_W'(IDX_W'(i) - ret_idx)} < live_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      ret_q  <= '0;
      tail_q <= '0;
    end else begin
      if (flush) begin
        tail_q <= ret_q;
      end else begin
        if (do_alloc)  tail_q <= tail_q + PTR_ONE;
        if (do_retire) ret_q  <= ret_q + PTR_ONE;
      end
      if (do_free) head_q <= head_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      resolved_q <= '0;
      retired_q  <= '0;
    end else begin
      if (do_alloc) begin
        valid_q[tail_idx]    <= 1'b1;
        resolved_q[tail_idx] <= 1'b0;
        retired_q[tail_idx]  <= 1'b0;
      end
      if (do_exec)   resolved_q[exec_index] <= 1'b1;
      if (do_retire) retired_q[ret_idx]     <= 1'b1;
      if (flush)     valid_q <= valid_q & ~flush_mask;
      if (do_free) begin
        valid_q[head_idx]   <= 1'b0;
        retired_q[head_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) id_q[tail_idx] <= alloc_active_list_id;
    if (do_exec) begin
      addr_q[exec_index] <= exec_addr;
      data_q[exec_index] <= exec_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SQ_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SQ_IDLE: if ((head_q != ret_q) && resolved_q[head_idx]) state_d = SQ_REQ;
      SQ_REQ:  if (cache_done) state_d = SQ_IDLE;
      default: state_d = SQ_IDLE;
    endcase
  end

  always_comb begin
    dispatch_valid = (state_q == SQ_REQ);
    dispatch_index = head_idx;
    dispatch_addr  = addr_q[head_idx];
    dispatch_data  = data_q[head_idx];
    dbg_state      = state_q;
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == SQ_REQ) |-> (resolved_q[head_idx] && retired_q[head_idx]));

  sq_bypass_search #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_bypass (
    .lookup_valid  (lookup_valid),
    .lookup_addr   (lookup_addr),
    .lookup_tail   (lookup_tail),
    .head          (head_q),
    .entry_valid   (valid_q),
    .entry_resolved(resolved_q),
    .entry_addr    (addr_q),
    .entry_data    (data_q),
    .hit           (bypass_hit),
    .hit_index     (bypass_index),
    .hit_data      (bypass_data),
    .unknown       (bypass_unknown)
  );

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Directed bench for store_queue_ctrl: ordered dispatch, full/wrap, flush, bypass table, mismatch and reset.
module tb_store_queue_ctrl;
  import mips_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [5:0]  alloc_active_list_id = '0;
  logic        alloc_ready;
  logic [2:0]  alloc_index;
  logic        exec_valid = 1'b0;
  logic [2:0]  exec_index = '0;
  logic [31:0] exec_addr = '0;
  logic [31:0] exec_data = '0;
  logic        retire_valid = 1'b0;
  logic [5:0]  retire_active_list_id = '0;
  logic        retire_mismatch;
  logic        flush = 1'b0;
  logic        dispatch_valid;
  logic [2:0]  dispatch_index;
  logic [31:0] dispatch_addr;
  logic [31:0] dispatch_data;
  logic        cache_done = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_addr = '0;
  logic [3:0]  lookup_tail = '0;
  logic        bypass_hit;
  logic [2:0]  bypass_index;
  logic [31:0] bypass_data;
  logic        bypass_unknown;
  sq_state_e   dbg_state;

  int n_checks = 0;
  int n_err = 0;

  store_queue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_active_list_id(alloc_active_list_id),
    .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .exec_valid(exec_valid), .exec_index(exec_index), .exec_addr(exec_addr), .exec_data(exec_data),
    .retire_valid(retire_valid), .retire_active_list_id(retire_active_list_id),
    .retire_mismatch(retire_mismatch), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_index(dispatch_index),
    .dispatch_addr(dispatch_addr), .dispatch_data(dispatch_data), .cache_done(cache_done),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_tail(lookup_tail),
    .bypass_hit(bypass_hit), .bypass_index(bypass_index), .bypass_data(bypass_data),
    .bypass_unknown(bypass_unknown), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        lv;
    logic [31:0] addr;
    logic [3:0]  tail;
    logic        exp_hit;
    logic [2:0]  exp_idx;
    logic [31:0] exp_data;
    logic        exp_unk;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    alloc_valid = 1'b0; exec_valid = 1'b0; retire_valid = 1'b0;
    flush = 1'b0; cache_done = 1'b0; lookup_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_alloc(input logic [5:0] id);
    alloc_valid = 1'b1;
    alloc_active_list_id = id;
    cyc();
    alloc_valid = 1'b0;
  endtask

  task automatic do_exec(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d);
    exec_valid = 1'b1; exec_index = idx; exec_addr = a; exec_data = d;
    cyc();
    exec_valid = 1'b0;
  endtask

  task automatic do_retire(input logic [5:0] id);
    retire_valid = 1'b1;
    retire_active_list_id = id;
    cyc();
    retire_valid = 1'b0;
  endtask

  task automatic wait_req(input string name, output bit ok);
    int w = 0;
    while (!dispatch_valid && w < 20) begin
      cyc();
      w++;
    end
    ok = dispatch_valid;
    check({name, " req_seen"}, 64'(dispatch_valid), 64'd1);
  endtask

  task automatic dispatch_one(input string name, input logic [2:0] idx,
                              input logic [31:0] a, input logic [31:0] d);
    bit ok;
    wait_req(name, ok);
    if (ok) begin
      check({name, " index"}, 64'(dispatch_index), 64'(idx));
      check({name, " addr"}, 64'(dispatch_addr), 64'(a));
      check({name, " data"}, 64'(dispatch_data), 64'(d));
      cyc();
      check({name, " hold_addr"}, 64'(dispatch_addr), 64'(a));
      cache_done = 1'b1;
      cyc();
      cache_done = 1'b0;
      check({name, " drop_after_done"}, 64'(dispatch_valid), 64'd0);
    end
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      lookup_valid = vecs[i].lv;
      lookup_addr  = vecs[i].addr;
      lookup_tail  = vecs[i].tail;
      #1;
      check($sformatf("lookup%0d hit", i), 64'(bypass_hit), 64'(vecs[i].exp_hit));
      check($sformatf("lookup%0d index", i), 64'(bypass_index), 64'(vecs[i].exp_idx));
      check($sformatf("lookup%0d data", i), 64'(bypass_data), 64'(vecs[i].exp_data));
      check($sformatf("lookup%0d unknown", i), 64'(bypass_unknown), 64'(vecs[i].exp_unk));
    end
    lookup_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    // lv, addr, tail, hit, idx, data, unknown
    vecs[0] = '{1'b1, 32'h200, 4'd2, 1'b1, 3'd1, 32'h22, 1'b0};
    vecs[1] = '{1'b1, 32'h200, 4'd1, 1'b1, 3'd0, 32'h11, 1'b0};
    vecs[2] = '{1'b1, 32'h204, 4'd2, 1'b0, 3'd0, 32'h0,  1'b0};
    vecs[3] = '{1'b1, 32'h200, 4'd0, 1'b0, 3'd0, 32'h0,  1'b0};
    vecs[4] = '{1'b0, 32'h200, 4'd2, 1'b0, 3'd0, 32'h0,  1'b0};
    vecs[5] = '{1'b1, 32'h300, 4'd2, 1'b0, 3'd0, 32'h0,  1'b1};
    vecs[6] = '{1'b1, 32'h300, 4'd1, 1'b1, 3'd0, 32'h33, 1'b0};
    vecs[7] = '{1'b1, 32'h300, 4'd3, 1'b1, 3'd2, 32'h55, 1'b0};
    vecs[8] = '{1'b1, 32'h304, 4'd3, 1'b0, 3'd0, 32'h0,  1'b1};

    // Reset state
    apply_reset();
    check("rst dispatch_valid", 64'(dispatch_valid), 64'd0);
    check("rst retire_mismatch", 64'(retire_mismatch), 64'd0);
    check("rst bypass_hit", 64'(bypass_hit), 64'd0);
    check("rst bypass_unknown", 64'(bypass_unknown), 64'd0);
    check("rst alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst alloc_index", 64'(alloc_index), 64'd0);
    check("rst state", 64'(dbg_state), 64'(SQ_IDLE));

    // Three stores dispatched in program order
    do_alloc(6'd5); do_alloc(6'd6); do_alloc(6'd7);
    do_exec(3'd0, 32'h100, 32'hAA);
    do_exec(3'd1, 32'h104, 32'hBB);
    do_exec(3'd2, 32'h108, 32'hCC);
    do_retire(6'd5); do_retire(6'd6); do_retire(6'd7);
    dispatch_one("st0", 3'd0, 32'h100, 32'hAA);
    dispatch_one("st1", 3'd1, 32'h104, 32'hBB);
    dispatch_one("st2", 3'd2, 32'h108, 32'hCC);
    check("t1 head", 64'(dut.head_q), 64'd3);
    check("t1 tail", 64'(dut.tail_q), 64'd3);
    check("t1 alloc_ready", 64'(alloc_ready), 64'd1);
    retire_valid = 1'b1; retire_active_list_id = 6'd7;
    #1 check("t1 retire_empty_mismatch", 64'(retire_mismatch), 64'd1);
    cyc();
    retire_valid = 1'b0;
    check("t1 ret unchanged", 64'(dut.ret_q), 64'd3);

    // Fill, ignored 9th alloc, free-while-full, wrap
    apply_reset();
    for (int i = 0; i < 8; i++) do_alloc(6'(10 + i));
    check("t2 full ready", 64'(alloc_ready), 64'd0);
    check("t2 full tail", 64'(dut.tail_q), 64'h8);
    do_alloc(6'd63);
    check("t2 ninth tail", 64'(dut.tail_q), 64'h8);
    check("t2 ninth id0", 64'(dut.id_q[0]), 64'd10);
    do_exec(3'd0, 32'h400, 32'h44);
    do_retire(6'd10);
    wait_req("t2", ok);
    if (ok) begin
      cache_done = 1'b1;
      alloc_valid = 1'b1;
      alloc_active_list_id = 6'd62;
      #1 check("t2 ready during free", 64'(alloc_ready), 64'd0);
      cyc();
      cache_done = 1'b0;
      alloc_valid = 1'b0;
      check("t2 tail after free", 64'(dut.tail_q), 64'h8);
      check("t2 head after free", 64'(dut.head_q), 64'd1);
      check("t2 ready after free", 64'(alloc_ready), 64'd1);
      check("t2 alloc_index wrap", 64'(alloc_index), 64'd0);
      do_alloc(6'd20);
      check("t2 wrap tail", 64'(dut.tail_q), 64'h9);
      check("t2 wrap valid0", 64'(dut.valid_q[0]), 64'd1);
      check("t2 wrap id0", 64'(dut.id_q[0]), 64'd20);
    end

    // Flush keeps retired stores, squashes the rest; exec loses to flush
    apply_reset();
    do_alloc(6'd1); do_alloc(6'd2); do_alloc(6'd3); do_alloc(6'd4);
    do_exec(3'd0, 32'h10, 32'hA0);
    do_exec(3'd1, 32'h14, 32'hA1);
    do_exec(3'd2, 32'h18, 32'hA2);
    do_retire(6'd1); do_retire(6'd2);
    flush = 1'b1;
    exec_valid = 1'b1; exec_index = 3'd3; exec_addr = 32'h1C; exec_data = 32'hA3;
    cyc();
    flush = 1'b0;
    exec_valid = 1'b0;
    check("t3 tail", 64'(dut.tail_q), 64'd2);
    check("t3 ret", 64'(dut.ret_q), 64'd2);
    check("t3 valid2", 64'(dut.valid_q[2]), 64'd0);
    check("t3 valid3", 64'(dut.valid_q[3]), 64'd0);
    check("t3 resolved3", 64'(dut.resolved_q[3]), 64'd0);
    dispatch_one("t3 st0", 3'd0, 32'h10, 32'hA0);
    dispatch_one("t3 st1", 3'd1, 32'h14, 32'hA1);
    check("t3 head", 64'(dut.head_q), 64'd2);
    check("t3 alloc_index", 64'(alloc_index), 64'd2);

    // Bypass: two resolved stores to one address
    apply_reset();
    do_alloc(6'd1); do_alloc(6'd2);
    do_exec(3'd0, 32'h200, 32'h11);
    do_exec(3'd1, 32'h200, 32'h22);
    apply_vecs(0, 4);

    // Bypass: unresolved store between matches
    apply_reset();
    do_alloc(6'd1); do_alloc(6'd2); do_alloc(6'd3);
    do_exec(3'd0, 32'h300, 32'h33);
    do_exec(3'd2, 32'h300, 32'h55);
    apply_vecs(5, 8);

    // Retire mismatch, then reset during REQ
    apply_reset();
    do_alloc(6'd5);
    do_exec(3'd0, 32'h500, 32'h55);
    retire_valid = 1'b1; retire_active_list_id = 6'd9;
    #1 check("t6 mismatch", 64'(retire_mismatch), 64'd1);
    cyc();
    retire_valid = 1'b0;
    #1 check("t6 mismatch pulse", 64'(retire_mismatch), 64'd0);
    check("t6 ret unchanged", 64'(dut.ret_q), 64'd0);
    do_retire(6'd5);
    check("t6 ret advanced", 64'(dut.ret_q), 64'd1);
    wait_req("t6", ok);
    #2 rst_n = 1'b0;
    #1 check("t6 async drop", 64'(dispatch_valid), 64'd0);
    check("t6 async state", 64'(dbg_state), 64'(SQ_IDLE));
    cyc();
    rst_n = 1'b1;
    #1;
    check("t6 head", 64'(dut.head_q), 64'd0);
    check("t6 ret", 64'(dut.ret_q), 64'd0);
    check("t6 tail", 64'(dut.tail_q), 64'd0);
    check("t6 alloc_ready", 64'(alloc_ready), 64'd1);
    check("t6 alloc_index", 64'(alloc_index), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
